exhaust_ctrl_gen: RTL and testbench

Parametrised range-hood exhaust controller and successor to the fixed 3-level controller.
- Supports LEVELS normal fan levels plus one turbo level; turbo is allowed once per power cycle.
- Turbo and return-to-idle countdowns have configurable lengths and are timed by an internal 1 s tick generator.
- Sits between the debounced key inputs and the display/motor-drive blocks.

---
 rtl/exhaust_ctrl_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_exhaust_ctrl_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exhaust_ctrl_gen.sv
// Range-hood exhaust controller: LEVELS normal fan levels plus a once-per-power-cycle turbo, 1 s tick timed.
// Optional macro EXHAUST_MENU_TIMEOUT_EN adds a MENU inactivity timeout of MENU_SEC seconds.
module exhaust_ctrl_gen #(
  parameter int CLK_HZ     = 100000000,
  parameter int LEVELS     = 2,
  parameter int TURBO_SEC  = 60,
  parameter int RETURN_SEC = 60,
  parameter int CNT_W      = 8
`ifdef EXHAUST_MENU_TIMEOUT_EN
  ,
  parameter int MENU_SEC   = 10
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power_on,
  input  logic              menu_key,
  input  logic [LEVELS-1:0] level_key,
  input  logic              turbo_key,
  output logic [2:0]        level,
  output logic              busy,
  output logic              menu_active,
  output logic [CNT_W-1:0]  countdown,
  output logic              countdown_active,
  output logic              turbo_used
);

  localparam int         DIV_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [2:0] TOP_LVL   = 3'(LEVELS);
  localparam logic [2:0] TURBO_LVL = 3'(LEVELS + 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_MENU,
    S_RUN,
    S_TURBO,
    S_RETURN
  } state_t;

  state_t             r_state, w_state_next;
  logic [2:0]         r_level, w_level_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_turbo_used, w_turbo_used_next;
  logic [DIV_W-1:0]   r_div, w_div_next;
  logic               r_power_prev, r_menu_prev, r_turbo_prev;
  logic [LEVELS-1:0]  r_level_prev;

  logic               w_power_rise, w_menu_rise, w_turbo_rise;
  logic [LEVELS-1:0]  w_level_rise;
  logic               w_level_any;
  logic [2:0]         w_level_sel;
  logic               w_tick;
  logic               w_div_restart;

`ifdef EXHAUST_MENU_TIMEOUT_EN
  localparam int MT_W = (MENU_SEC > 1) ? $clog2(MENU_SEC + 1) : 1;
  logic [MT_W-1:0] r_menu_ticks, w_menu_ticks_next;
`endif

  assign w_power_rise = power_on & ~r_power_prev;
  assign w_menu_rise  = menu_key & ~r_menu_prev;
  assign w_turbo_rise = turbo_key & ~r_turbo_prev;
  assign w_level_any  = |w_level_rise;
  assign w_tick       = (r_div == DIV_W'(CLK_HZ - 1));

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level_edge
      assign w_level_rise[gi] = level_key[gi] & ~r_level_prev[gi];
    end
  endgenerate

  // Scan from the top down so the lowest rising index is the one that sticks.
  always_comb begin
    w_level_sel = 3'd0;
    for (int i = LEVELS - 1; i >= 0; i--) begin
      if (w_level_rise[i]) begin
        w_level_sel = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_OFF;
      r_level      <= 3'd0;
      r_cnt        <= '0;
      r_turbo_used <= 1'b0;
      r_div        <= '0;
      r_power_prev <= 1'b0;
      r_menu_prev  <= 1'b0;
      r_turbo_prev <= 1'b0;
      r_level_prev <= '0;
    end else begin
      r_state      <= w_state_next;
      r_level      <= w_level_next;
      r_cnt        <= w_cnt_next;
      r_turbo_used <= w_turbo_used_next;
      r_div        <= w_div_next;
      r_power_prev <= power_on;
      r_menu_prev  <= menu_key;
      r_turbo_prev <= turbo_key;
      r_level_prev <= level_key;
    end
  end

`ifdef EXHAUST_MENU_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_menu_ticks <= '0;
    end else begin
      r_menu_ticks <= w_menu_ticks_next;
    end
  end
`endif

  always_comb begin
    w_state_next      = r_state;
    w_level_next      = r_level;
    w_cnt_next        = r_cnt;
    w_turbo_used_next = r_turbo_used;
    w_div_restart     = 1'b0;
`ifdef EXHAUST_MENU_TIMEOUT_EN
    w_menu_ticks_next = r_menu_ticks;
`endif

    // Losing power overrides every key and timer event.
    if (!power_on && (r_state != S_OFF)) begin
      w_state_next = S_OFF;
      w_level_next = 3'd0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (w_power_rise) begin
            w_state_next      = S_IDLE;
            w_turbo_used_next = 1'b0;
          end
        end
        S_IDLE: begin
          if (w_menu_rise) begin
            w_state_next  = S_MENU;
            w_div_restart = 1'b1;
`ifdef EXHAUST_MENU_TIMEOUT_EN
            w_menu_ticks_next = '0;
`endif
          end
        end
        S_MENU: begin
          if (w_level_any) begin
            w_state_next = S_RUN;
            w_level_next = w_level_sel;
          end else if (w_turbo_rise && !r_turbo_used) begin
            w_state_next  = S_TURBO;
            w_cnt_next    = CNT_W'(TURBO_SEC);
            w_div_restart = 1'b1;
          end else if (w_menu_rise) begin
            w_state_next = S_IDLE;
`ifdef EXHAUST_MENU_TIMEOUT_EN
          end else if (w_turbo_rise) begin
            // A refused turbo press still counts as activity.
            w_div_restart     = 1'b1;
            w_menu_ticks_next = '0;
          end else if (w_tick) begin
            if (r_menu_ticks >= MT_W'(MENU_SEC - 1)) begin
              w_state_next = S_IDLE;
            end else begin
              w_menu_ticks_next = r_menu_ticks + 1'b1;
            end
`endif
          end
        end
        S_RUN: begin
          if (w_menu_rise) begin
            w_state_next = S_IDLE;
            w_level_next = 3'd0;
          end else if (w_level_any && (w_level_sel != r_level)) begin
            w_level_next = w_level_sel;
          end
        end
        S_TURBO: begin
          if (w_menu_rise) begin
            w_state_next      = S_RETURN;
            w_cnt_next        = CNT_W'(RETURN_SEC);
            w_turbo_used_next = 1'b1;
            w_div_restart     = 1'b1;
          end else if (w_tick) begin
            if (r_cnt <= CNT_W'(1)) begin
              w_state_next      = S_RUN;
              w_level_next      = TOP_LVL;
              w_cnt_next        = '0;
              w_turbo_used_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt - 1'b1;
            end
          end
        end
        S_RETURN: begin
          if (w_tick) begin
            if (r_cnt <= CNT_W'(1)) begin
              w_state_next = S_IDLE;
              w_level_next = 3'd0;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt - 1'b1;
            end
          end
        end
        default: begin
          w_state_next = S_OFF;
          w_level_next = 3'd0;
          w_cnt_next   = '0;
        end
      endcase
    end

    if (w_div_restart || w_tick) begin
      w_div_next = '0;
    end else begin
      w_div_next = r_div + 1'b1;
    end
  end

  always_comb begin
    level            = 3'd0;
    busy             = 1'b0;
    menu_active      = 1'b0;
    countdown_active = 1'b0;
    case (r_state)
      S_MENU: menu_active = 1'b1;
      S_RUN: begin
        level = r_level;
        busy  = 1'b1;
      end
      S_TURBO, S_RETURN: begin
        level            = TURBO_LVL;
        busy             = 1'b1;
        countdown_active = 1'b1;
      end
      default: begin
        level = 3'd0;
      end
    endcase
  end

  assign countdown  = countdown_active ? r_cnt : '0;
  assign turbo_used = r_turbo_used;

endmodule

// File: tb/tb_exhaust_ctrl_gen.sv
// Self-checking bench for exhaust_ctrl_gen: vector table, timed corner sequences and a randomized run
// compared against an elapsed-time behavioural model.
module tb_exhaust_ctrl_gen;

  localparam int CLK_HZ     = 10;
  localparam int LEVELS     = 2;
  localparam int TURBO_SEC  = 3;
  localparam int RETURN_SEC = 2;
  localparam int CNT_W      = 8;
`ifdef EXHAUST_MENU_TIMEOUT_EN
  localparam int MENU_SEC   = 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              power_on;
  logic              menu_key;
  logic [LEVELS-1:0] level_key;
  logic              turbo_key;
  logic [2:0]        level;
  logic              busy;
  logic              menu_active;
  logic [CNT_W-1:0]  countdown;
  logic              countdown_active;
  logic              turbo_used;

  always #5 clk = ~clk;

  exhaust_ctrl_gen #(
    .CLK_HZ    (CLK_HZ),
    .LEVELS    (LEVELS),
    .TURBO_SEC (TURBO_SEC),
    .RETURN_SEC(RETURN_SEC),
    .CNT_W     (CNT_W)
`ifdef EXHAUST_MENU_TIMEOUT_EN
    ,
    .MENU_SEC  (MENU_SEC)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .power_on        (power_on),
    .menu_key        (menu_key),
    .level_key       (level_key),
    .turbo_key       (turbo_key),
    .level           (level),
    .busy            (busy),
    .menu_active     (menu_active),
    .countdown       (countdown),
    .countdown_active(countdown_active),
    .turbo_used      (turbo_used)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode plus the cycle at which the current timed interval began.
  typedef enum int {M_OFF, M_IDLE, M_MENU, M_RUN, M_TURBO, M_RETURN} mmode_t;
  mmode_t            m_mode;
  int                m_lvl;
  bit                m_used;
  int                m_k;
  int                m_anchor;
  logic              p_pw, p_menu, p_turbo;
  logic [LEVELS-1:0] p_lvl;
  int e_level, e_busy, e_mact, e_cd, e_cda, e_used;

  typedef struct {
    logic        pw;
    logic        menu;
    logic [1:0]  lvl;
    logic        turbo;
    int          lev;
    int          busy;
    int          mact;
    int          cd;
    int          cda;
    int          used;
    string       name;
  } vec_t;
  vec_t vecs[$];

  function automatic int lowest_set(input logic [LEVELS-1:0] v);
    for (int i = 0; i < LEVELS; i++) begin
      if (v[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_outputs();
    int el;
    el     = m_k - m_anchor;
    e_used = int'(m_used);
    e_mact = (m_mode == M_MENU) ? 1 : 0;
    e_busy = (m_mode == M_RUN || m_mode == M_TURBO || m_mode == M_RETURN) ? 1 : 0;
    e_cda  = (m_mode == M_TURBO || m_mode == M_RETURN) ? 1 : 0;
    e_level = (m_mode == M_RUN) ? m_lvl : (e_cda == 1) ? LEVELS + 1 : 0;
    if (m_mode == M_TURBO)       e_cd = TURBO_SEC - el / CLK_HZ;
    else if (m_mode == M_RETURN) e_cd = RETURN_SEC - el / CLK_HZ;
    else                         e_cd = 0;
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_lvl = 0; m_used = 0; m_k = 0; m_anchor = 0;
    p_pw = 0; p_menu = 0; p_turbo = 0; p_lvl = '0;
    model_outputs();
  endtask

  task automatic model_step();
    bit pw_r, mn_r, tb_r;
    int lsel, el;
    pw_r = power_on & ~p_pw;
    mn_r = menu_key & ~p_menu;
    tb_r = turbo_key & ~p_turbo;
    lsel = lowest_set(level_key & ~p_lvl);
    m_k++;
    el = m_k - m_anchor;
    if (!power_on) begin
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF:  if (pw_r) begin m_mode = M_IDLE; m_used = 0; end
        M_IDLE: if (mn_r) begin m_mode = M_MENU; m_anchor = m_k; end
        M_MENU: begin
          if (lsel != 0) begin m_mode = M_RUN; m_lvl = lsel; end
          else if (tb_r && !m_used) begin m_mode = M_TURBO; m_anchor = m_k; end
          else if (mn_r) m_mode = M_IDLE;
`ifdef EXHAUST_MENU_TIMEOUT_EN
          else if (tb_r) m_anchor = m_k;
          else if (el >= MENU_SEC * CLK_HZ) m_mode = M_IDLE;
`endif
        end
        M_RUN: begin
          if (mn_r) m_mode = M_IDLE;
          else if (lsel != 0) m_lvl = lsel;
        end
        M_TURBO: begin
          if (mn_r) begin m_mode = M_RETURN; m_anchor = m_k; m_used = 1; end
          else if (el >= TURBO_SEC * CLK_HZ) begin m_mode = M_RUN; m_lvl = LEVELS; m_used = 1; end
        end
        M_RETURN: if (el >= RETURN_SEC * CLK_HZ) m_mode = M_IDLE;
        default: m_mode = M_OFF;
      endcase
    end
    p_pw = power_on; p_menu = menu_key; p_turbo = turbo_key; p_lvl = level_key;
    model_outputs();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_level", int'(level), e_level);
    chk("model_busy", int'(busy), e_busy);
    chk("model_menu_active", int'(menu_active), e_mact);
    chk("model_countdown", int'(countdown), e_cd);
    chk("model_countdown_active", int'(countdown_active), e_cda);
    chk("model_turbo_used", int'(turbo_used), e_used);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_level"}, int'(level), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_menu_active"}, int'(menu_active), 0);
    chk({nm, "_countdown"}, int'(countdown), 0);
    chk({nm, "_countdown_active"}, int'(countdown_active), 0);
    chk({nm, "_turbo_used"}, int'(turbo_used), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic step(input logic pw, input logic mn, input logic [1:0] lv, input logic tb);
    power_on = pw; menu_key = mn; level_key = lv; turbo_key = tb;
    cycle();
  endtask

  // Asynchronous reset applied between edges; outputs must clear without waiting for clk.
  task automatic async_reset(input string nm);
    rst = 1'b1;
    #2;
    model_reset();
    check_zero(nm);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic void add_vec(input logic pw, input logic mn, input logic [1:0] lv,
                                  input logic tb, input int lev, input int bz, input int ma,
                                  input int cd, input int cda, input int used, input string nm);
    vec_t v;
    v.pw = pw; v.menu = mn; v.lvl = lv; v.turbo = tb;
    v.lev = lev; v.busy = bz; v.mact = ma; v.cd = cd; v.cda = cda; v.used = used; v.name = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1'b1; power_on = 0; menu_key = 0; level_key = '0; turbo_key = 0;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    //         pw mn lvl   tb  lev bz ma cd cda used
    add_vec(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "power_on");
    add_vec(1, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0, "menu_enter");
    add_vec(1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, "menu_release");
    add_vec(1, 0, 2'b10, 0, 2, 1, 0, 0, 0, 0, "select_lvl2");
    add_vec(1, 0, 2'b00, 0, 2, 1, 0, 0, 0, 0, "lvl_release");
    add_vec(1, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, "switch_lvl1");
    add_vec(1, 0, 2'b00, 1, 1, 1, 0, 0, 0, 0, "turbo_ignored_run");
    add_vec(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "menu_to_idle");
    add_vec(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "idle_hold");
    add_vec(1, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0, "menu_enter2");
    add_vec(1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, "menu_release2");
    add_vec(1, 1, 2'b11, 0, 1, 1, 0, 0, 0, 0, "lvl11_with_menu");
    add_vec(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "power_drop");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].pw, vecs[i].menu, vecs[i].lvl, vecs[i].turbo);
      chk({"vec_", vecs[i].name, "_level"}, int'(level), vecs[i].lev);
      chk({"vec_", vecs[i].name, "_busy"}, int'(busy), vecs[i].busy);
      chk({"vec_", vecs[i].name, "_menu_active"}, int'(menu_active), vecs[i].mact);
      chk({"vec_", vecs[i].name, "_countdown"}, int'(countdown), vecs[i].cd);
      chk({"vec_", vecs[i].name, "_countdown_active"}, int'(countdown_active), vecs[i].cda);
      chk({"vec_", vecs[i].name, "_turbo_used"}, int'(turbo_used), vecs[i].used);
      $display("vec %0d %s: level=%0d busy=%0b menu=%0b cd=%0d used=%0b",
               i, vecs[i].name, level, busy, menu_active, countdown, turbo_used);
    end

    // Turbo timing: countdown steps once every CLK_HZ cycles after entry.
    step(1, 0, 2'b00, 0);
    step(1, 1, 2'b00, 0);
    step(1, 0, 2'b00, 1);
    chk("turbo_entry_level", int'(level), 3);
    chk("turbo_entry_cd", int'(countdown), 3);
    chk("turbo_entry_cda", int'(countdown_active), 1);
    step(1, 0, 2'b00, 0);
    repeat (8) cycle();
    chk("turbo_cd_at_9", int'(countdown), 3);
    cycle();
    chk("turbo_cd_at_10", int'(countdown), 2);
    repeat (10) cycle();
    chk("turbo_cd_at_20", int'(countdown), 1);
    repeat (9) cycle();
    chk("turbo_level_at_29", int'(level), 3);
    cycle();
    chk("turbo_expire_level", int'(level), 2);
    chk("turbo_expire_cd", int'(countdown), 0);
    chk("turbo_expire_used", int'(turbo_used), 1);
    $display("seq turbo: level=%0d cd=%0d used=%0b", level, countdown, turbo_used);

    // Turbo refused once consumed; power toggle re-arms it.
    step(1, 1, 2'b00, 0);
    step(1, 0, 2'b00, 0);
    step(1, 1, 2'b00, 0);
    step(1, 0, 2'b00, 1);
    chk("turbo_refused_level", int'(level), 0);
    chk("turbo_refused_menu", int'(menu_active), 1);
    step(0, 0, 2'b00, 0);
    chk("power_off_used_held", int'(turbo_used), 1);
    chk("power_off_level", int'(level), 0);
    step(1, 0, 2'b00, 0);
    chk("power_on_used_clear", int'(turbo_used), 0);
    step(1, 1, 2'b00, 0);
    step(1, 0, 2'b00, 1);
    chk("turbo_rearmed_level", int'(level), 3);
    $display("seq rearm: level=%0d used=%0b", level, turbo_used);

    // Menu during turbo forces a RETURN countdown that ignores keys.
    turbo_key = 0;
    repeat (10) cycle();
    chk("turbo_cd_before_return", int'(countdown), 2);
    step(1, 1, 2'b00, 0);
    chk("return_cd", int'(countdown), 2);
    chk("return_level", int'(level), 3);
    chk("return_used", int'(turbo_used), 1);
    for (int i = 1; i <= 20; i++) begin
      step(1, 1'(i % 2), (i % 3 == 1) ? 2'b01 : 2'b00, 1'(i % 4 == 1));
      if (i == 10) chk("return_cd_at_10", int'(countdown), 1);
      if (i == 19) chk("return_level_at_19", int'(level), 3);
    end
    chk("return_done_level", int'(level), 0);
    chk("return_done_busy", int'(busy), 0);
    chk("return_done_cda", int'(countdown_active), 0);
    $display("seq return: level=%0d busy=%0b cda=%0b", level, busy, countdown_active);

    // Reset asserted in the middle of a turbo run.
    step(0, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0);
    step(1, 1, 2'b00, 0);
    step(1, 0, 2'b00, 1);
    chk("pre_reset_turbo_level", int'(level), 3);
    repeat (3) step(1, 0, 2'b00, 0);
    async_reset("midturbo_reset");
    $display("seq reset: level=%0d busy=%0b", level, busy);

    step(1, 0, 2'b00, 0);
    step(1, 1, 2'b00, 0);
`ifdef EXHAUST_MENU_TIMEOUT_EN
    repeat (19) step(1, 0, 2'b00, 0);
    chk("menu_before_timeout", int'(menu_active), 1);
    step(1, 0, 2'b00, 0);
    chk("menu_timeout_menu", int'(menu_active), 0);
    chk("menu_timeout_level", int'(level), 0);
    step(1, 1, 2'b00, 0);
    repeat (14) step(1, 0, 2'b00, 0);
    step(1, 0, 2'b10, 0);
    chk("menu_clk15_level", int'(level), 2);
`else
    repeat (30) step(1, 0, 2'b00, 0);
    chk("menu_waits", int'(menu_active), 1);
    step(1, 0, 2'b10, 0);
    chk("menu_late_level", int'(level), 2);
`endif
    $display("seq menu_wait: level=%0d menu=%0b", level, menu_active);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      if (power_on) begin
        if ($urandom_range(149) == 0) power_on = 0;
      end else if ($urandom_range(3) == 0) begin
        power_on = 1;
      end
      if ($urandom_range(11) == 0) menu_key = ~menu_key;
      for (int b = 0; b < LEVELS; b++) begin
        if ($urandom_range(9) == 0) level_key[b] = ~level_key[b];
      end
      if ($urandom_range(7) == 0) turbo_key = ~turbo_key;
      cycle();
    end
    $display("random: 4000 cycles, level=%0d used=%0b", level, turbo_used);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
